// File: rtl/hive_thrd_seq.sv
// Round-robin PC sequencer for the barrel pipeline: issues one thread per enabled clock,
// retires each thread's flow-control decision LAT clocks later, and injects clear/irq vectors.
module hive_thrd_seq #(
    parameter int              THRDS      = 8,
    parameter int              PC_W       = 16,
    parameter int              LAT        = 4,
    parameter logic [PC_W-1:0] CLR_BASE   = 'h0000,
    parameter logic [PC_W-1:0] IRQ_BASE   = 'h0020,
    parameter logic [PC_W-1:0] VEC_STRIDE = 'h0004
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [THRDS-1:0]         clr_req_i,
    input  logic [THRDS-1:0]         irq_req_i,
    input  logic                     jmp_i,
    input  logic                     res_i,
    input  logic [PC_W-1:0]          tgt_i,
    input  logic                     rti_i,
    output logic [$clog2(THRDS)-1:0] thrd_o,
    output logic [PC_W-1:0]          pc_o,
    output logic                     pc_vld_o,
    output logic [THRDS-1:0]         isr_act_o,
    output logic [THRDS-1:0]         clr_ack_o,
    output logic [THRDS-1:0]         irq_ack_o
);

    localparam int THRD_W = $clog2(THRDS);
    localparam logic [PC_W-1:0]   PC_ONE  = 1;
    localparam logic [THRD_W-1:0] CNT_ONE = 1;

    function automatic logic [PC_W-1:0] vec(input logic [PC_W-1:0] base,
                                            input logic [THRD_W-1:0] idx);
        return base + PC_W'(idx) * VEC_STRIDE;
    endfunction

    logic [THRD_W-1:0] cnt;
    logic [PC_W-1:0]   pc      [THRDS];
    logic [PC_W-1:0]   ret     [THRDS];
    logic [PC_W-1:0]   pc_nxt  [THRDS];
    logic [PC_W-1:0]   ret_nxt [THRDS];
    logic [THRDS-1:0]  isr_act, clr_pnd, irq_pnd;
    logic [THRDS-1:0]  isr_nxt, clr_nxt, irq_nxt;
    logic              do_clr, do_irq;

    // retire tag: the issue outputs seen LAT clocks earlier
    logic [THRD_W-1:0] rt_thrd;
    logic [PC_W-1:0]   rt_pc;
    logic              rt_vld;

    if (LAT == 1) begin : g_nopipe
        assign rt_thrd = thrd_o;
        assign rt_pc   = pc_o;
        assign rt_vld  = pc_vld_o;
    end else begin : g_pipe
        logic [THRD_W-1:0] thrd_p [LAT-1];
        logic [PC_W-1:0]   pc_p   [LAT-1];
        logic [LAT-2:0]    vld_p;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) vld_p <= '0;
            else       vld_p <= {vld_p[LAT-2:0], pc_vld_o} [LAT-2:0];
        end

        always_ff @(posedge clk_i) begin
            thrd_p[0] <= thrd_o;
            pc_p[0]   <= pc_o;
            for (int k = 1; k < LAT-1; k++) begin
                thrd_p[k] <= thrd_p[k-1];
                pc_p[k]   <= pc_p[k-1];
            end
        end

        assign rt_thrd = thrd_p[LAT-2];
        assign rt_pc   = pc_p[LAT-2];
        assign rt_vld  = vld_p[LAT-2];
    end

    // Retire and issue never hit the same thread, so both updates merge here.
    always_comb begin
        pc_nxt  = pc;
        ret_nxt = ret;
        isr_nxt = isr_act;
        clr_nxt = clr_pnd;
        irq_nxt = irq_pnd;
        do_clr  = en_i & clr_pnd[cnt];
        do_irq  = en_i & ~clr_pnd[cnt] & irq_pnd[cnt] & ~isr_act[cnt];

        if (rt_vld) begin
            if (rti_i && isr_act[rt_thrd]) begin
                pc_nxt[rt_thrd]  = ret[rt_thrd];
                isr_nxt[rt_thrd] = 1'b0;
            end else if (jmp_i && res_i) begin
                pc_nxt[rt_thrd] = tgt_i;
            end else begin
                pc_nxt[rt_thrd] = rt_pc + PC_ONE;
            end
        end

        if (do_clr) begin
            pc_nxt[cnt]  = vec(CLR_BASE, cnt);
            isr_nxt[cnt] = 1'b0;
            clr_nxt[cnt] = 1'b0;
            irq_nxt[cnt] = 1'b0;
        end else if (do_irq) begin
            ret_nxt[cnt] = pc[cnt];
            pc_nxt[cnt]  = vec(IRQ_BASE, cnt);
            isr_nxt[cnt] = 1'b1;
            irq_nxt[cnt] = 1'b0;
        end

        // requests landing in the service clock survive to the next round
        clr_nxt = clr_nxt | clr_req_i;
        irq_nxt = irq_nxt | irq_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            thrd_o    <= '0;
            pc_o      <= '0;
            pc_vld_o  <= 1'b0;
            clr_ack_o <= '0;
            irq_ack_o <= '0;
            isr_act   <= '0;
            clr_pnd   <= '0;
            irq_pnd   <= '0;
            for (int n = 0; n < THRDS; n++) begin
                pc[n]  <= vec(CLR_BASE, THRD_W'(n));
                ret[n] <= '0;
            end
        end else begin
            pc        <= pc_nxt;
            ret       <= ret_nxt;
            isr_act   <= isr_nxt;
            clr_pnd   <= clr_nxt;
            irq_pnd   <= irq_nxt;
            clr_ack_o <= THRDS'(do_clr) << cnt;
            irq_ack_o <= THRDS'(do_irq) << cnt;
            pc_vld_o  <= en_i & ~do_clr & ~do_irq;
            if (en_i) begin
                cnt    <= cnt + CNT_ONE;
                thrd_o <= cnt;
                if (!do_clr && !do_irq) pc_o <= pc[cnt];
            end
        end
    end

    assign isr_act_o = isr_act;

endmodule
